px_stream_framer: RTL and testbench
===================================

PX_STREAM_FRAMER -- requirements
Module: px_stream_framer

Interface
REQ-001 Parameter PX_SIZE, default 8: pixel width in bits.
REQ-002 Parameter IMAGE_WIDTH, default 640: pixels per line.
REQ-003 Parameter IMAGE_HEIGHT, default 480: lines per frame.
REQ-004 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two, 2 or more.
REQ-005 clk  in  1: single clock; all logic is on its rising edge.
REQ-006 resetn  in  1: reset, asynchronous and active-low.
REQ-007 clear  in  1: synchronous soft clear; same effect as reset.
REQ-008 in_data  in  PX_SIZE: pixel from the processing top.
REQ-009 in_valid  in  1: in_data is valid this cycle; push-only, with no backpressure.
REQ-010 out_data  out  PX_SIZE: buffered pixel.
REQ-011 out_sof / out_eol / out_eof  out  1 each: start of frame, end of line and end of frame, aligned with out_data.
REQ-012 out_valid  out  1; out_ready  in  1: a transfer happens when both are 1.
REQ-013 frame_done  out  1: one-cycle pulse when a complete frame has drained.
REQ-014 overflow  out  1: sticky flag; a pixel was dropped because the FIFO was full.
REQ-015 extra_px  out  1: sticky flag; a pixel arrived in the DONE state.

Function
REQ-016 The block SHALL use the states IDLE, ACTIVE and DONE.
REQ-017 IDLE->ACTIVE SHALL occur on the first in_valid; that pixel is tagged sof.
REQ-018 The column counter col and line counter line SHALL each be 12 bits and advance once per accepted in_valid. col wraps at IMAGE_WIDTH-1 to 0 and then line increments.
REQ-019 Pixel tags SHALL be computed as follows:
- sof = (col==0 && line==0)
- eol = (col==IMAGE_WIDTH-1)
- eof = eol && (line==IMAGE_HEIGHT-1)
REQ-020 On the eof pixel the block SHALL go to DONE, and col and line SHALL return to 0.
REQ-021 In DONE, in_valid SHALL be dropped without pushing, and extra_px SHALL be set.
REQ-022 DONE->IDLE SHALL occur when the FIFO is empty; frame_done SHALL be 1 for exactly that cycle.
REQ-023 Latency: with the FIFO empty, in_valid at edge n SHALL give out_valid=1 after edge n, with no combinational path from input to output.
REQ-024 The FIFO SHALL preserve order and store {data, sof, eol, eof} per entry.
REQ-025 FIFO full with no pop in the same cycle: the pixel SHALL be dropped, overflow SHALL be set, and col and line SHALL still advance so that frame geometry is preserved.
REQ-026 FIFO full with a pop in the same cycle: the push SHALL succeed and no overflow SHALL be flagged.
REQ-027 FIFO empty with push and pop in the same cycle: the push SHALL be accepted, and out_valid SHALL be 1 from the next cycle.
REQ-028 out_data and the tag outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 If clear and in_valid occur in the same cycle, clear SHALL win and the pixel SHALL be discarded.

Reset
REQ-030 Reset values SHALL be:
- state IDLE; col=0, line=0; FIFO empty
- out_valid=0, out_data=0, all tags 0
- frame_done=0, overflow=0, extra_px=0
REQ-031 Reset asserted mid-frame SHALL abandon the partial frame; the next in_valid after release SHALL start a new frame tagged sof.
REQ-032 Reset SHALL take effect asynchronously; release is sampled on clk.

Configuration
REQ-033 With PX_FRAMER_DROP_CNT_EN defined, the block SHALL add the output drop_cnt (16 bits).
- drop_cnt increments on every dropped pixel, covering both the overflow case and the DONE case.
- drop_cnt saturates at 0xFFFF.
- drop_cnt is cleared by reset and by clear.
REQ-034 Without PX_FRAMER_DROP_CNT_EN, the port and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-035 The package px_stream_pkg SHALL hold:
- the default PX_SIZE constant
- the counter width constant (12)
- the framer state enum
- the FIFO entry struct {data, sof, eol, eof}
REQ-036 The sub-module px_fifo SHALL be a synchronous FIFO, parameterised by entry width and depth, with full/empty outputs; px_stream_framer instantiates it.

Verification
Benches use IMAGE_WIDTH=4, IMAGE_HEIGHT=2 and FIFO_DEPTH=4 unless stated otherwise.
REQ-037 8 consecutive in_valid pixels 1..8 with out_ready=1 -> outputs 1..8 in order:
- sof on 1
- eol on 4 and 8
- eof on 8
- frame_done pulses once, one cycle after pixel 8 drains
REQ-038 out_ready=0 while 5 pixels are pushed -> pixels 1..4 are buffered, overflow=1, and 5 is lost; the last line still ends with eof at the 8th pixel.
REQ-039 FIFO full with out_ready=1 and in_valid in the same cycle -> no overflow, and the FIFO stays full.
REQ-040 After eof, 2 more in_valid pulses before the drain completes -> extra_px=1 and no additional outputs; with PX_FRAMER_DROP_CNT_EN defined, drop_cnt=2.
REQ-041 resetn low after pixel 3, then released, then pixels 10..17 sent -> outputs are 10..17 with sof on 10, and no output of pixels 1..3.
REQ-042 clear asserted together with in_valid on pixel 2 -> pixel 2 is discarded, and the next pixel is tagged sof.

Source files
------------

// File: rtl/px_stream_pkg.sv
// Shared types and constants for the pixel stream framer.
// Holds the default pixel width, the line/column counter width, the framer
// state enum and the per-pixel FIFO entry layout {data, sof, eol, eof}.
package px_stream_pkg;

   localparam int unsigned PX_SIZE_DEF = 8;
   localparam int unsigned CNT_W       = 12;
   localparam int unsigned DROP_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } px_state_t;

   // Position tags that travel with each pixel.
   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } px_tags_t;

   // Full FIFO entry at the default pixel width.
   typedef struct packed {
      logic [PX_SIZE_DEF-1:0] data;
      logic                   sof;
      logic                   eol;
      logic                   eof;
   } px_entry_t;

endpackage

// File: rtl/px_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Ports: clk, rst_n (async active-low), clear (sync), push/wdata, pop/rdata,
// full, empty. A push while full is accepted only when a pop happens in the
// same cycle; rdata is the head entry and is valid whenever empty is 0.
module px_fifo #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) count_nxt = count + (AW+1)'(1);
      if (do_pop && !do_push) count_nxt = count - (AW+1)'(1);
   end

   // Storage, pointers and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else if (clear) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/px_stream_framer.sv
// Pixel stream framer: tags an unthrottled pixel stream with sof/eol/eof from
// column/line counters and buffers it in a small FIFO for a ready/valid sink.
// Ports: clk, resetn (async active-low), clear (sync soft clear),
//   in_data/in_valid (push-only input), out_data/out_sof/out_eol/out_eof/
//   out_valid/out_ready (output stream), frame_done (drain pulse),
//   overflow and extra_px (sticky drop flags),
//   drop_cnt (only when PX_FRAMER_DROP_CNT_EN is defined).
module px_stream_framer
   import px_stream_pkg::*;
#(
   parameter int unsigned PX_SIZE      = PX_SIZE_DEF,
   parameter int unsigned IMAGE_WIDTH  = 640,
   parameter int unsigned IMAGE_HEIGHT = 480,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clear,
   input  logic [PX_SIZE-1:0]    in_data,
   input  logic                  in_valid,
   output logic [PX_SIZE-1:0]    out_data,
   output logic                  out_sof,
   output logic                  out_eol,
   output logic                  out_eof,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  frame_done,
   output logic                  overflow,
`ifdef PX_FRAMER_DROP_CNT_EN
   output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
   output logic                  extra_px
);

   localparam int unsigned TAG_W   = $bits(px_tags_t);
   localparam int unsigned ENTRY_W = PX_SIZE + TAG_W;

   px_state_t          state;
   px_state_t          state_nxt;
   logic [CNT_W-1:0]   col;
   logic [CNT_W-1:0]   line;
   px_tags_t           tags_in;
   px_tags_t           tags_out;
   logic [ENTRY_W-1:0] fifo_wdata;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               count_px;
   logic               drop_ovf;
   logic               drop_done;

   // Tags for the pixel arriving this cycle.
   assign tags_in.sof = (col == '0) && (line == '0);
   assign tags_in.eol = (col == CNT_W'(IMAGE_WIDTH - 1));
   assign tags_in.eof = tags_in.eol && (line == CNT_W'(IMAGE_HEIGHT - 1));

   // A pixel counts toward the frame geometry even if the FIFO drops it.
   assign pop       = !fifo_empty && out_ready;
   assign count_px  = in_valid && !clear && (state != ST_DONE);
   assign drop_ovf  = count_px && fifo_full && !pop;
   assign drop_done = in_valid && !clear && (state == ST_DONE);

   assign fifo_wdata = {in_data, tags_in};

   px_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (resetn),
      .clear (clear),
      .push  (count_px),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_rdata[ENTRY_W-1 -: PX_SIZE];
   assign tags_out  = px_tags_t'(fifo_rdata[TAG_W-1:0]);
   assign out_sof   = tags_out.sof;
   assign out_eol   = tags_out.eol;
   assign out_eof   = tags_out.eof;

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (count_px) state_nxt = tags_in.eof ? ST_DONE : ST_ACTIVE;
         ST_ACTIVE: if (count_px && tags_in.eof) state_nxt = ST_DONE;
         ST_DONE:   if (fifo_empty) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    state <= ST_IDLE;
      else if (clear) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // Column/line counters; both return to zero after the eof pixel.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col  <= '0;
         line <= '0;
      end else if (clear) begin
         col  <= '0;
         line <= '0;
      end else if (count_px) begin
         if (tags_in.eof) begin
            col  <= '0;
            line <= '0;
         end else if (tags_in.eol) begin
            col  <= '0;
            line <= line + CNT_W'(1);
         end else begin
            col  <= col + CNT_W'(1);
         end
      end
   end

   // Status flags: frame_done marks the DONE->IDLE transition.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         extra_px   <= 1'b0;
      end else if (clear) begin
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         extra_px   <= 1'b0;
      end else begin
         frame_done <= (state == ST_DONE) && fifo_empty;
         if (drop_ovf)  overflow <= 1'b1;
         if (drop_done) extra_px <= 1'b1;
      end
   end

`ifdef PX_FRAMER_DROP_CNT_EN
   // Saturating count of every dropped pixel.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    drop_cnt <= '0;
      else if (clear) drop_cnt <= '0;
      else if ((drop_ovf || drop_done) && (drop_cnt != '1))
         drop_cnt <= drop_cnt + DROP_CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_px_stream_framer.sv
// Testbench for px_stream_framer (W=4, H=2, FIFO depth 4).
// Directed scenarios plus a randomized run, checked every cycle against a
// queue-based frame model; optional drop counter under PX_FRAMER_DROP_CNT_EN.
module tb_px_stream_framer;

   localparam int W = 4;
   localparam int H = 2;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic [7:0] out_data;
   logic       out_sof, out_eol, out_eof, out_valid;
   logic       out_ready = 1'b0;
   logic       frame_done, overflow, extra_px;
`ifdef PX_FRAMER_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // Model state: entries are {data, sof, eol, eof}.
   logic [10:0] exp_q[$];
   logic [10:0] got[$];
   logic [10:0] want[$];
   int m_idx;
   bit m_done, m_ovf, m_extra, m_fd;
   int m_drops;
   int fd_cnt;

   px_stream_framer #(
      .PX_SIZE      (8),
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .clear      (clear),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_sof    (out_sof),
      .out_eol    (out_eol),
      .out_eof    (out_eof),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .overflow   (overflow),
`ifdef PX_FRAMER_DROP_CNT_EN
      .drop_cnt   (drop_cnt),
`endif
      .extra_px   (extra_px)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mk(input int d, input bit s, input bit l, input bit f);
      mk = {8'(d), s, l, f};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_idx = 0; m_done = 0; m_ovf = 0; m_extra = 0; m_fd = 0; m_drops = 0;
   endtask

   task automatic check_outputs();
      logic [10:0] e;
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         e = exp_q[0];
         chk("out_data", out_data, e[10:3]);
         chk("out_sof", out_sof, e[2]);
         chk("out_eol", out_eol, e[1]);
         chk("out_eof", out_eof, e[0]);
      end
      chk("frame_done", frame_done, m_fd);
      chk("overflow", overflow, m_ovf);
      chk("extra_px", extra_px, m_extra);
`ifdef PX_FRAMER_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
`endif
   endtask

   // One clock: drive, advance, update the model, then compare.
   task automatic step(input bit iv, input int d, input bit rdy, input bit clr);
      bit pop, acc, sof, eol, eof;
      int col, line;
      in_valid  = iv;
      in_data   = 8'(d);
      out_ready = rdy;
      clear     = clr;
      if (out_valid && rdy && !clr) got.push_back({out_data, out_sof, out_eol, out_eof});
      @(posedge clk);
      pop  = (exp_q.size() > 0) && rdy;
      m_fd = 0;
      if (clr) begin
         model_reset();
      end else if (m_done) begin
         if (iv) begin m_extra = 1; m_drops++; end
         if (exp_q.size() == 0) begin m_done = 0; m_fd = 1; end
         if (pop) void'(exp_q.pop_front());
      end else begin
         acc = iv && ((exp_q.size() < D) || pop);
         if (pop) void'(exp_q.pop_front());
         if (iv) begin
            col  = m_idx % W;
            line = m_idx / W;
            sof  = (m_idx == 0);
            eol  = (col == W - 1);
            eof  = eol && (line == H - 1);
            if (acc) exp_q.push_back(mk(d, sof, eol, eof));
            else begin m_ovf = 1; m_drops++; end
            m_idx++;
            if (eof) begin m_idx = 0; m_done = 1; end
         end
      end
      #1;
      if (frame_done) fd_cnt++;
      check_outputs();
   endtask

   // Reset asserted between edges; checks it acts before any clock.
   task automatic async_reset();
      in_valid = 0; out_ready = 0; clear = 0;
      #2 resetn = 1'b0;
      #1;
      model_reset();
      chk("rst_async_valid", out_valid, 0);
      chk("rst_async_data", out_data, 0);
      chk("rst_async_tags", {out_sof, out_eol, out_eof}, 0);
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      resetn = 1'b1;
      got.delete();
      fd_cnt = 0;
   endtask

   task automatic cmp_list(input string tag);
      chk({tag, "_len"}, got.size(), want.size());
      for (int i = 0; i < want.size() && i < got.size(); i++)
         chk({tag, "_item"}, got[i], want[i]);
   endtask

   initial begin
      model_reset();
      fd_cnt = 0;
      @(posedge clk);
      #1;
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_tags", {out_sof, out_eol, out_eof}, 0);
      chk("reset_flags", {frame_done, overflow, extra_px}, 0);
      resetn = 1'b1;

      // Full frame, sink always ready.
      for (int i = 1; i <= 8; i++) step(1, i, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
      want = {mk(1,1,0,0), mk(2,0,0,0), mk(3,0,0,0), mk(4,0,1,0),
              mk(5,0,0,0), mk(6,0,0,0), mk(7,0,0,0), mk(8,0,1,1)};
      cmp_list("frame8");
      chk("frame8_done_pulses", fd_cnt, 1);

      // Overflow: fifth pixel lost, geometry preserved.
      async_reset();
      for (int i = 1; i <= 5; i++) step(1, i, 0, 0);
      chk("ovf_flag", overflow, 1);
      for (int i = 6; i <= 8; i++) step(1, i, 1, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
      want = {mk(1,1,0,0), mk(2,0,0,0), mk(3,0,0,0), mk(4,0,1,0),
              mk(6,0,0,0), mk(7,0,0,0), mk(8,0,1,1)};
      cmp_list("ovf");

      // Full FIFO with simultaneous pop accepts the push and stays full.
      async_reset();
      for (int i = 1; i <= 4; i++) step(1, i, 0, 0);
      step(1, 5, 1, 0);
      chk("full_pop_no_ovf", overflow, 0);
      step(1, 6, 0, 0);
      chk("still_full_ovf", overflow, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

      // Pixels arriving while the frame drains.
      async_reset();
      for (int i = 1; i <= 8; i++) step(1, 20 + i, 1, 0);
      step(1, 99, 0, 0);
      step(1, 98, 0, 0);
      chk("extra_flag", extra_px, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
      chk("extra_out_count", got.size(), 8);
      chk("extra_no_ovf", overflow, 0);
`ifdef PX_FRAMER_DROP_CNT_EN
      chk("extra_drop_cnt", drop_cnt, 2);
`endif

      // Reset mid-frame abandons the partial frame.
      async_reset();
      for (int i = 1; i <= 3; i++) step(1, i, 0, 0);
      async_reset();
      for (int i = 10; i <= 17; i++) step(1, i, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
      want = {mk(10,1,0,0), mk(11,0,0,0), mk(12,0,0,0), mk(13,0,1,0),
              mk(14,0,0,0), mk(15,0,0,0), mk(16,0,0,0), mk(17,0,1,1)};
      cmp_list("midrst");

      // Clear together with a pixel: clear wins, next pixel restarts the frame.
      async_reset();
      step(1, 1, 0, 0);
      step(1, 2, 0, 1);
      step(1, 3, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      want = {mk(3,1,0,0)};
      cmp_list("clear");

      // Randomized traffic.
      async_reset();
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 99) < 55, int'($urandom_range(0, 255)),
              $urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
